// File: rtl/sel_shift_pkg.sv
// Shared types, saturation limits and the add/sub helper for sel_shift_pipe.
// Define SEL_SHIFT_SAT_EN to make d/e/f saturate instead of wrap.
package sel_shift_pkg;

    localparam int DATAWIDTH = 32;

    typedef logic signed [DATAWIDTH-1:0] word_t;

    localparam word_t SMAX = {1'b0, {(DATAWIDTH-1){1'b1}}};
    localparam word_t SMIN = {1'b1, {(DATAWIDTH-1){1'b0}}};

    typedef struct packed {
        word_t d;
        word_t e;
        word_t f;
    } s1_t;

    typedef struct packed {
        word_t x;
        word_t z;
        logic  lt;
        logic  eq;
    } s2_t;

    function automatic word_t sat_add(input word_t a, input word_t b, input logic sub);
`ifdef SEL_SHIFT_SAT_EN
        logic signed [DATAWIDTH:0] s;
        s = sub ? ({a[DATAWIDTH-1], a} - {b[DATAWIDTH-1], b})
                : ({a[DATAWIDTH-1], a} + {b[DATAWIDTH-1], b});
        // The two top bits disagree exactly when the true result left the range
        if (s[DATAWIDTH] != s[DATAWIDTH-1])
            return s[DATAWIDTH] ? SMIN : SMAX;
        return s[DATAWIDTH-1:0];
`else
        return sub ? (a - b) : (a + b);
`endif
    endfunction

endpackage

// File: rtl/sel_shift_pipe_if.sv
// Operand/result handshake bundle for sel_shift_pipe.
interface sel_shift_pipe_if #(parameter int W = 32);

    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic signed [W-1:0] c;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] x;
    logic signed [W-1:0] z;
    logic                out_lt;
    logic                out_eq;

    modport slave (
        input  in_valid, a, b, c, out_ready,
        output in_ready, out_valid, x, z, out_lt, out_eq
    );

    modport master (
        output in_valid, a, b, c, out_ready,
        input  in_ready, out_valid, x, z, out_lt, out_eq
    );

endinterface

// File: rtl/sel_shift_pipe_stage.sv
// One valid/ready register slice; the upstream may push whenever the slot is
// empty or is being drained this cycle.
module pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             adv;

    assign adv        = !valid_q || out_ready_i;
    assign in_ready_o = adv;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (adv) begin
            valid_d = in_valid_i;
            // Payload only moves on a real beat, so an empty advance leaves it untouched
            if (in_valid_i) data_d = data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign data_o      = data_q;

endmodule

// File: rtl/sel_shift_pipe.sv
// Two-stage add/compare/select/shift pipeline with valid/ready flow control.
// Optional SEL_SHIFT_SAT_EN saturates d/e/f (see sel_shift_pkg::sat_add).
module sel_shift_pipe
    import sel_shift_pkg::*;
#(
    parameter int SHAMT = 1
) (
    input  logic                clk,
    input  logic                rst,
    sel_shift_pipe_if.slave     io
);

    s1_t   s1_d, s1_q;
    s2_t   s2_d, s2_q;
    logic  s1_valid, s2_ready;
    word_t g, h;

    always_comb begin
        s1_d   = '0;
        s1_d.d = sat_add(io.a, io.b, 1'b0);
        s1_d.e = sat_add(io.a, io.c, 1'b0);
        s1_d.f = sat_add(io.a, io.b, 1'b1);
    end

    pipe_stage #(.WIDTH($bits(s1_t))) u_s1 (
        .clk         (clk),
        .rst_n       (rst),
        .in_valid_i  (io.in_valid),
        .in_ready_o  (io.in_ready),
        .data_i      (s1_d),
        .out_valid_o (s1_valid),
        .out_ready_i (s2_ready),
        .data_o      (s1_q)
    );

    always_comb begin
        s2_d    = '0;
        s2_d.lt = s1_q.d < s1_q.e;
        s2_d.eq = s1_q.d == s1_q.e;
        g       = s2_d.lt ? s1_q.e : s1_q.d;
        h       = s2_d.eq ? s1_q.f : g;
        s2_d.x  = s2_d.lt ? (g <<  SHAMT) : g;
        s2_d.z  = s2_d.eq ? (h >>> SHAMT) : h;
    end

    pipe_stage #(.WIDTH($bits(s2_t))) u_s2 (
        .clk         (clk),
        .rst_n       (rst),
        .in_valid_i  (s1_valid),
        .in_ready_o  (s2_ready),
        .data_i      (s2_d),
        .out_valid_o (io.out_valid),
        .out_ready_i (io.out_ready),
        .data_o      (s2_q)
    );

    assign io.x      = s2_q.x;
    assign io.z      = s2_q.z;
    assign io.out_lt = s2_q.lt;
    assign io.out_eq = s2_q.eq;

endmodule

// File: tb/tb_sel_shift_pipe.sv
// Directed + randomized bench for sel_shift_pipe against a queue-based integer model.
module tb_sel_shift_pipe;

    localparam int SH = 1;

    logic clk;
    logic rst;

    sel_shift_pipe_if #(.W(32)) bus ();

    sel_shift_pipe #(.SHAMT(SH)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x;
        int z;
        bit lt;
        bit eq;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   prev_stall = 0;
    int   prev_x, prev_z;
    bit   acc, rdy;
    int   k, cyc;
    bit   rdy_at2;
    int   ra, rb, rc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic longint fix(input longint v);
`ifdef SEL_SHIFT_SAT_EN
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
`else
        return longint'(int'(v));
`endif
    endfunction

    function automatic exp_t model(input int a, input int b, input int c);
        exp_t   r;
        longint d, e, f, g, h;
        d = fix(longint'(a) + longint'(b));
        e = fix(longint'(a) + longint'(c));
        f = fix(longint'(a) - longint'(b));
        r.lt = d < e;
        r.eq = d == e;
        g = r.lt ? e : d;
        h = r.eq ? f : g;
        r.x = int'(r.lt ? g * (64'sd1 << SH) : g);
        r.z = int'(r.eq ? (h >>> SH) : h);
        return r;
    endfunction

    function automatic int rand_op();
        case ($urandom_range(3))
            0:       return int'($urandom_range(40)) - 20;
            1:       return 32'h7FFF_FFFF - int'($urandom_range(3));
            2:       return 32'h8000_0000 + int'($urandom_range(3));
            default: return int'($urandom);
        endcase
    endfunction

    // One handshake cycle: drive at posedge+1, judge transfers at negedge.
    task automatic run_cycle(input bit iv, input int ia, input int ib, input int ic,
                             input bit ordy, output bit accepted, output bit ready_seen);
        exp_t e;
        bus.in_valid  = iv;
        bus.a         = ia;
        bus.b         = ib;
        bus.c         = ic;
        bus.out_ready = ordy;
        @(negedge clk);
        ready_seen = bus.in_ready;
        if (prev_stall) begin
            chk("stall_x_stable", bus.x, prev_x);
            chk("stall_z_stable", bus.z, prev_z);
        end
        if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", 32'(bus.out_valid), 32'd0);
            end else begin
                e = q.pop_front();
                chk("x", bus.x, e.x);
                chk("z", bus.z, e.z);
                chk("lt", 32'(bus.out_lt), 32'(e.lt));
                chk("eq", 32'(bus.out_eq), 32'(e.eq));
            end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_x     = bus.x;
        prev_z     = bus.z;
        accepted   = iv && bus.in_ready;
        if (accepted) q.push_back(model(ia, ib, ic));
        @(posedge clk);
        #1;
    endtask

    task automatic single_beat(input string tag, input int ia, input int ib, input int ic,
                               input int ex, input int ez, input bit elt, input bit eeq);
        bus.in_valid  = 1'b1;
        bus.a         = ia;
        bus.b         = ib;
        bus.c         = ic;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_not_yet"}, 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_x"}, bus.x, ex);
        chk({tag, "_z"}, bus.z, ez);
        chk({tag, "_lt"}, 32'(bus.out_lt), 32'(elt));
        chk({tag, "_eq"}, 32'(bus.out_eq), 32'(eeq));
        @(posedge clk);
        #1;
        prev_stall = 0;
    endtask

    initial begin
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c         = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_x", bus.x, 32'd0);
        chk("rst_z", bus.z, 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        single_beat("t1", 5, 3, 10, 30, 15, 1'b1, 1'b0);
        single_beat("t2", 4, 2, 2, 6, 1, 1'b0, 1'b1);
        single_beat("t3", -8, -8, 0, -16, -8, 1'b1, 1'b0);
`ifdef SEL_SHIFT_SAT_EN
        single_beat("t4", 32'h7FFF_FFFF, 1, 0, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 1'b0, 1'b1);
`else
        single_beat("t4", 32'h7FFF_FFFF, 1, 0, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 1'b1, 1'b0);
`endif

        // Backpressure: 4 beats, consumer stalled for the first 3 cycles
        k = 0;
        rdy_at2 = 1'b1;
        for (cyc = 0; cyc < 30 && (k < 4 || q.size() > 0); cyc++) begin
            run_cycle(k < 4, 100 + k, k, 7 * k, cyc >= 3, acc, rdy);
            if (cyc == 2) rdy_at2 = rdy;
            if (acc) k++;
        end
        chk("bp_in_ready_drop", 32'(rdy_at2), 32'd0);
        chk("bp_all_sent", 32'(k), 32'd4);
        chk("bp_drained", 32'(q.size()), 32'd0);

        // Random stream with random backpressure
        for (int i = 0; i < 400; i++) begin
            ra = rand_op();
            rb = rand_op();
            rc = ($urandom_range(3) == 0) ? rb : rand_op();
            run_cycle($urandom_range(3) != 0, ra, rb, rc, $urandom_range(9) < 7, acc, rdy);
        end
        for (int i = 0; i < 20 && q.size() > 0; i++)
            run_cycle(1'b0, 0, 0, 0, 1'b1, acc, rdy);
        chk("rand_drained", 32'(q.size()), 32'd0);

        // Reset with both stages occupied
        run_cycle(1'b1, 1, 2, 3, 1'b0, acc, rdy);
        run_cycle(1'b1, 4, 5, 6, 1'b0, acc, rdy);
        bus.in_valid = 1'b0;
        #2;
        chk("mid_full", 32'(bus.out_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_x", bus.x, 32'd0);
        chk("mid_rst_z", bus.z, 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        q.delete();
        prev_stall = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_empty", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        single_beat("t6", 5, 3, 10, 30, 15, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
